// File: rtl/clint_ctrl.sv
// Core-local trap/mret sequencer: holds the pipeline, writes mepc/mstatus/mcause
// (or restores mstatus on mret) through a dedicated CSR port, then redirects fetch.
module clint_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     inst_i,
    input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
    input  logic                      jump_flag_i,
    input  logic [ADDR_WIDTH-1:0]     jump_addr_i,
    input  logic                      irq_i,
    input  logic [DATA_WIDTH-1:0]     mstatus_i,
    input  logic [DATA_WIDTH-1:0]     mtvec_i,
    input  logic [DATA_WIDTH-1:0]     mepc_i,
    output logic                      hold_o,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
    output logic                      flush_interrupt_o,
    output logic [ADDR_WIDTH-1:0]     int_addr_o
);

    localparam logic [DATA_WIDTH-1:0] INST_ECALL   = DATA_WIDTH'(32'h0000_0073);
    localparam logic [DATA_WIDTH-1:0] INST_EBREAK  = DATA_WIDTH'(32'h0010_0073);
    localparam logic [DATA_WIDTH-1:0] INST_MRET    = DATA_WIDTH'(32'h3020_0073);

    localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL  = DATA_WIDTH'(32'd11);
    localparam logic [DATA_WIDTH-1:0] CAUSE_EBREAK = DATA_WIDTH'(32'd3);
    localparam logic [DATA_WIDTH-1:0] CAUSE_EXT    = DATA_WIDTH'(32'h8000_000B);

    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);

    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    typedef enum logic [2:0] {
        IDLE,
        MEPC_WR,
        MSTATUS_WR,
        MCAUSE_WR,
        MRET_WR,
        JUMP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] cause;
    logic [DATA_WIDTH-1:0] epc;
    logic [DATA_WIDTH-1:0] mstatus_q;
    logic [DATA_WIDTH-1:0] mepc_q;
    logic                  is_mret;

    logic                  is_ecall;
    logic                  sync_req;
    logic                  mret_req;
    logic                  async_req;
    logic [DATA_WIDTH-1:0] mstatus_trap;
    logic [DATA_WIDTH-1:0] mstatus_ret;
    logic [DATA_WIDTH-1:0] trap_target;

    // Wrong-path instructions (EX jump taken) are ignored; the async line is not.
    always_comb begin
        is_ecall  = (inst_i == INST_ECALL);
        sync_req  = !jump_flag_i && (is_ecall || (inst_i == INST_EBREAK));
        mret_req  = !jump_flag_i && (inst_i == INST_MRET);
        async_req = irq_i && mstatus_i[MIE_BIT];
    end

    always_comb begin
        mstatus_trap           = mstatus_q;
        mstatus_trap[MPIE_BIT] = mstatus_q[MIE_BIT];
        mstatus_trap[MIE_BIT]  = 1'b0;
        mstatus_ret            = mstatus_q;
        mstatus_ret[MIE_BIT]   = mstatus_q[MPIE_BIT];
        mstatus_ret[MPIE_BIT]  = 1'b1;
        trap_target            = mtvec_i & ~DATA_WIDTH'(3);
    end

    // Sequencer state and trap context capture; inputs only sampled in IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cause     <= '0;
            epc       <= '0;
            mstatus_q <= '0;
            mepc_q    <= '0;
            is_mret   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sync_req) begin
                        cause     <= is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                        epc       <= DATA_WIDTH'(inst_addr_i);
                        mstatus_q <= mstatus_i;
                        is_mret   <= 1'b0;
                        state     <= MEPC_WR;
                    end else if (mret_req) begin
                        mstatus_q <= mstatus_i;
                        mepc_q    <= mepc_i;
                        is_mret   <= 1'b1;
                        state     <= MRET_WR;
                    end else if (async_req) begin
                        cause     <= CAUSE_EXT;
                        epc       <= jump_flag_i ? DATA_WIDTH'(jump_addr_i)
                                                 : DATA_WIDTH'(inst_addr_i);
                        mstatus_q <= mstatus_i;
                        is_mret   <= 1'b0;
                        state     <= MEPC_WR;
                    end
                end
                MEPC_WR:    state <= MSTATUS_WR;
                MSTATUS_WR: state <= MCAUSE_WR;
                MCAUSE_WR:  state <= JUMP;
                MRET_WR:    state <= JUMP;
                JUMP:       state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

    // Moore decode of the CSR port and redirect from state and captured context.
    always_comb begin
        csr_we_o          = 1'b0;
        csr_waddr_o       = '0;
        csr_wdata_o       = '0;
        flush_interrupt_o = 1'b0;
        int_addr_o        = '0;
        case (state)
            MEPC_WR: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = epc;
            end
            MSTATUS_WR: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_trap;
            end
            MCAUSE_WR: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause;
            end
            MRET_WR: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_ret;
            end
            JUMP: begin
                flush_interrupt_o = 1'b1;
                int_addr_o        = is_mret ? ADDR_WIDTH'(mepc_q) : ADDR_WIDTH'(trap_target);
            end
            default: ;
        endcase
    end

    // Hold rises in the accepting IDLE cycle so the pipeline freezes on the trapping instruction.
    assign hold_o = (state != IDLE) || sync_req || mret_req || async_req;

endmodule

// File: doc/clint_ctrl.md
Name: clint_ctrl

Overview:
Core-local interrupt/exception sequencer for the 5-stage pipeline. It watches the ID-stage instruction, the EX-stage jump request and the external interrupt line. On a trap or mret it holds the pipeline, performs the machine-mode CSR updates through a dedicated CSR write port, then redirects fetch. It drives the pipeline's interrupt-flush input and the PC redirect.

Parameters:
DATA_WIDTH, 32, CSR data / instruction width
ADDR_WIDTH, 32, instruction address width
CSR_ADDR_WIDTH, 12, CSR address width

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-low reset
inst_i  in  DATA_WIDTH  instruction currently in ID
inst_addr_i  in  ADDR_WIDTH  PC of inst_i
jump_flag_i  in  1  EX-stage taken jump/branch this cycle
jump_addr_i  in  ADDR_WIDTH  EX-stage jump target
irq_i  in  1  external interrupt request, level, active-high
mstatus_i  in  DATA_WIDTH  current mstatus (bit3 MIE, bit7 MPIE)
mtvec_i  in  DATA_WIDTH  trap vector base (direct mode only)
mepc_i  in  DATA_WIDTH  saved return PC
hold_o  out  1  pipeline hold request to stall controller
csr_we_o  out  1  CSR write enable
csr_waddr_o  out  CSR_ADDR_WIDTH  CSR write address
csr_wdata_o  out  DATA_WIDTH  CSR write data
flush_interrupt_o  out  1  one-cycle flush of IF/ID and ID/EXE
int_addr_o  out  ADDR_WIDTH  redirect PC, valid while flush_interrupt_o=1

Behaviour:
- States: IDLE, MEPC_WR, MSTATUS_WR, MCAUSE_WR, MRET_WR, JUMP. All outputs except hold_o are Moore outputs decoded from the state and internal registers.
- Reset (rst_i=0 at a rising edge): state goes to IDLE and internal registers clear. All outputs read 0 in IDLE. Reset mid-sequence abandons it immediately, with no further CSR writes or flush.
- Decode in IDLE:
  - ecall = 0x00000073
  - ebreak = 0x00100073
  - mret = 0x30200073
  - async event = irq_i=1 and mstatus_i[3]=1
- Priority: sync (ecall/ebreak) > mret > async.
- Wrong-path guard: if jump_flag_i=1, the ID instruction is on the wrong path. ecall, ebreak and mret in ID are ignored that cycle. An async event is still taken.
- On a trap in IDLE (sync or async), capture the following, then go to MEPC_WR:
  - cause: ecall=11, ebreak=3, async=0x8000000B
  - epc: sync → inst_addr_i; async → jump_addr_i if jump_flag_i=1, else inst_addr_i
  - mstatus_i
- On mret in IDLE: capture mstatus_i and mepc_i, then go to MRET_WR.
- hold_o = 1 in every non-IDLE state, and combinationally in IDLE during the cycle a trap or mret is accepted.
- Trap sequence, one state per cycle:
  - MEPC_WR: we=1, addr=0x341, data=epc
  - MSTATUS_WR: we=1, addr=0x300, data=saved mstatus with bit7←bit3 and bit3←0
  - MCAUSE_WR: we=1, addr=0x342, data=cause
  - JUMP: flush_interrupt_o=1, int_addr_o={mtvec_i[ADDR_WIDTH-1:2],2'b00}
  - Then return to IDLE.
- mret sequence:
  - MRET_WR: we=1, addr=0x300, data=saved mstatus with bit3←bit7 and bit7←1
  - JUMP: int_addr_o=saved mepc
  - Then return to IDLE.
- Latency from accept edge: trap = 4 cycles to flush; mret = 2 cycles.
- Inputs are not sampled outside IDLE. irq_i and a new ecall are ignored mid-sequence. A still-pending irq is re-evaluated in IDLE against the updated mstatus, so it is masked while MIE=0.
- csr_waddr_o and csr_wdata_o are 0 whenever csr_we_o=0. int_addr_o is 0 whenever flush_interrupt_o=0.

Test Plan:
- ecall at 0x100, mtvec_i=0x80, mstatus_i=0x8 → writes 0x341←0x100, 0x300←0x80, 0x342←11 on consecutive cycles; then flush_interrupt_o=1 with int_addr_o=0x80; hold_o high for 5 cycles total.
- irq_i=1, mstatus_i=0x8, jump_flag_i=1, jump_addr_i=0x200 → mepc←0x200, mcause←0x8000000B; with mstatus_i=0x0 instead, no activity and hold_o=0.
- mret with mepc_i=0x104, mstatus_i=0x80 → 0x300←0x88 next cycle, then flush with int_addr_o=0x104.
- ecall and irq both present → cause 11 taken. ecall with jump_flag_i=1 and irq_i=0 → ignored, all outputs 0.
- irq_i held high throughout a trap; mstatus_i tracks the written value 0x80 → exactly one trap taken, no re-entry after return to IDLE.
- rst_i=0 asserted during MSTATUS_WR → next cycle IDLE, all outputs 0, no MCAUSE write and no flush.
